muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: size, 32, operand/result width in bits (even, >=4).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request; sampled only while idle.
REQ-005 SHALL have port: value1  input  size  operand rs1 (dividend / multiplicand).
REQ-006 SHALL have port: value2  input  size  operand rs2 (divisor / multiplier).
REQ-007 SHALL have port: func_type  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port: busy  output  1  high while an operation is in flight.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: result  output  size  registered result, held until next accepted start.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, CALC, FINISH.
REQ-012 In IDLE with start=1 at an edge: SHALL latch value1, value2, func_type; go to CALC; busy=1; iteration counter=0.
REQ-013 In CALC: SHALL perform one radix-2 step per cycle (shift-add multiply or restoring divide on magnitudes); after exactly size steps go to FINISH.
REQ-014 In FINISH: SHALL apply sign correction, register result, pulse done=1 for one cycle, return to IDLE with busy=0.
REQ-015 Latency SHALL be fixed: done high in the cycle after the (size+2)th edge counting the accepting edge as 1, independent of operand values.
REQ-016 start while busy=1 SHALL be ignored, with no effect on latched operands or result.
REQ-017 start asserted in the done cycle SHALL be accepted (back-to-back issue, no bubble).
REQ-018 Signedness: MUL/MULH/DIV/REM both signed; MULHSU value1 signed, value2 unsigned; MULHU/DIVU/REMU unsigned.
REQ-019 MUL SHALL return low size bits of the 2*size product; MULH/MULHSU/MULHU SHALL return the high size bits.
REQ-020 DIV/DIVU SHALL return the quotient truncated toward zero; REM/REMU the remainder, sign equal to dividend.
REQ-021 Divide by zero SHALL return quotient all-ones (DIV and DIVU) and remainder = value1 (REM and REMU), with normal latency.
REQ-022 Signed overflow (value1 = most-negative, value2 = -1) SHALL return DIV = value1, REM = 0, with normal latency.
REQ-023 Iteration counter SHALL be $clog2(size)+1 bits wide and SHALL not wrap within an operation.
REQ-024 done SHALL never be high while busy is high.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, busy=0, done=0, result=0, counter=0, in any state, including mid-CALC.
REQ-026 An operation interrupted by reset SHALL produce no done pulse; start sampled in the same edge as rst_n=0 SHALL be ignored.
REQ-027 First start SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-028 Op encodings (MUL..REMU) and FSM state encodings SHALL live in shared package alu_pkg, alongside the existing ALU func codes.
REQ-029 One combinational sub-module, muldiv_sign_fix, SHALL hold operand absolute-value and result negation logic; the FSM and datapath registers SHALL stay in muldiv_unit.

Verification (size=32)
REQ-030 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-032 DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; all with done at nominal latency.
REQ-033 Latency/handshake: start pulse -> busy rises next cycle, done exactly at REQ-015 cycle; start re-asserted during busy ignored; start in done cycle -> second result correct with no gap.
REQ-034 Reset mid-CALC (step 10) -> next cycle busy=0, done=0, result=0; no done pulse follows; fresh MUL 3 x 4 then returns 12.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU func codes, muldiv op codes and muldiv FSM states
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_func_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'd0,
        MD_CALC   = 2'd1,
        MD_FINISH = 2'd2
    } muldiv_state_e;

    // value1 is interpreted as two's complement for these ops
    function automatic logic op_signed1(input logic [2:0] op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    // value2 is interpreted as two's complement for these ops
    function automatic logic op_signed2(input logic [2:0] op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between a core and muldiv_unit
interface muldiv_unit_if #(parameter int size = 32);
    logic            start;
    logic [size-1:0] value1;
    logic [size-1:0] value2;
    logic [2:0]      func_type;
    logic            busy;
    logic            done;
    logic [size-1:0] result;

    modport master (output start, value1, value2, func_type, input busy, done, result);
    modport slave  (input start, value1, value2, func_type, output busy, done, result);
endinterface

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - operand magnitudes, result sign decision and result negation
module muldiv_sign_fix
    import alu_pkg::*;
#(
    parameter int size = 32
) (
    input  logic [size-1:0]   i_value1,
    input  logic [size-1:0]   i_value2,
    input  logic [2:0]        i_func,
    input  logic [2*size-1:0] i_raw,
    input  logic              i_neg,
    output logic [size-1:0]   o_mag1,
    output logic [size-1:0]   o_mag2,
    output logic              o_neg,
    output logic [2*size-1:0] o_fixed
);
    logic w_s1;
    logic w_s2;

    assign w_s1   = op_signed1(i_func) & i_value1[size-1];
    assign w_s2   = op_signed2(i_func) & i_value2[size-1];
    assign o_mag1 = w_s1 ? -i_value1 : i_value1;
    assign o_mag2 = w_s2 ? -i_value2 : i_value2;

    // Quotient of a divide by zero stays all-ones, so it is never negated;
    // remainder always takes the dividend's sign.
    always_comb begin
        o_neg = 1'b0;
        if (!i_func[2])
            o_neg = w_s1 ^ w_s2;
        else if (!i_func[1])
            o_neg = (w_s1 ^ w_s2) & (|i_value2);
        else
            o_neg = w_s1;
    end

    assign o_fixed = i_neg ? -i_raw : i_raw;
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit with fixed latency
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int size = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int              CW       = $clog2(size) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(size - 1);

    muldiv_state_e   r_state;
    logic [2:0]      r_func;
    logic [size-1:0] r_hi;
    logic [size-1:0] r_lo;
    logic [size-1:0] r_op;
    logic [size-1:0] r_result;
    logic [CW-1:0]   r_cnt;
    logic            r_neg;
    logic            r_busy;
    logic            r_done;

    logic [size-1:0]   w_mag1;
    logic [size-1:0]   w_mag2;
    logic              w_neg;
    logic [2*size-1:0] w_raw;
    logic [2*size-1:0] w_fixed;
    logic [size:0]     w_sum;
    logic [size:0]     w_shift;
    logic [size-1:0]   w_diff;
    logic              w_ge;

    muldiv_sign_fix #(.size(size)) u_sign_fix (
        .i_value1 (bus.value1),
        .i_value2 (bus.value2),
        .i_func   (bus.func_type),
        .i_raw    (w_raw),
        .i_neg    (r_neg),
        .o_mag1   (w_mag1),
        .o_mag2   (w_mag2),
        .o_neg    (w_neg),
        .o_fixed  (w_fixed)
    );

    // Multiply step: r_hi:r_lo is the product accumulator, multiplier shifts out of r_lo
    assign w_sum   = {1'b0, r_hi} + {1'b0, {size{r_lo[0]}} & r_op};
    // Divide step: r_hi is the partial remainder, dividend bits shift out of r_lo
    assign w_shift = {r_hi, r_lo[size-1]};
    assign w_ge    = w_shift >= {1'b0, r_op};
    assign w_diff  = w_shift[size-1:0] - r_op;

    // Select the unsigned magnitude result to be sign-corrected in FINISH
    always_comb begin
        w_raw = {r_hi, r_lo};
        case (r_func)
            MD_DIV, MD_DIVU: w_raw = {{size{1'b0}}, r_lo};
            MD_REM, MD_REMU: w_raw = {{size{1'b0}}, r_hi};
            default:         w_raw = {r_hi, r_lo};
        endcase
    end

    // Control FSM plus datapath registers; busy/done/result are registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= MD_IDLE;
            r_func   <= MD_MUL;
            r_hi     <= '0;
            r_lo     <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (bus.start) begin
                        r_func  <= bus.func_type;
                        r_hi    <= '0;
                        r_lo    <= bus.func_type[2] ? w_mag1 : w_mag2;
                        r_op    <= bus.func_type[2] ? w_mag2 : w_mag1;
                        r_neg   <= w_neg;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    if (!r_func[2]) begin
                        r_hi <= w_sum[size:1];
                        r_lo <= {w_sum[0], r_lo[size-1:1]};
                    end else begin
                        r_hi <= w_ge ? w_diff : w_shift[size-1:0];
                        r_lo <= {r_lo[size-2:0], w_ge};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST)
                        r_state <= MD_FINISH;
                end
                MD_FINISH: begin
                    if (r_func inside {MD_MULH, MD_MULHSU, MD_MULHU})
                        r_result <= w_fixed[2*size-1:size];
                    else
                        r_result <= w_fixed[size-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= MD_IDLE;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    import alu_pkg::*;

    localparam int SIZE = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    muldiv_unit_if #(.size(SIZE)) bus ();

    muldiv_unit #(.size(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arithmetic meaning of each op, straight from the instruction definitions
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] up;
        logic        ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MD_MUL:    begin p = sa * sb; up = p; return up[31:0];  end
            MD_MULH:   begin p = sa * sb; up = p; return up[63:32]; end
            MD_MULHSU: begin p = sa * ub; up = p; return up[63:32]; end
            MD_MULHU:  begin up = ua * ub;        return up[63:32]; end
            MD_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; up = p; return up[31:0];
            end
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM:    begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; up = p; return up[31:0];
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Reference model: an accepted op finishes SIZE+1 edges after acceptance
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pending = '0;
    logic        m_inflight = 1'b0;
    int          m_left = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_inflight = 1'b0;
                m_busy     = 1'b0;
                m_done     = 1'b0;
                m_result   = '0;
            end else begin
                m_done = 1'b0;
                if (m_inflight) begin
                    if (m_left == 1) begin
                        m_inflight = 1'b0;
                        m_busy     = 1'b0;
                        m_done     = 1'b1;
                        m_result   = m_pending;
                    end else begin
                        m_left--;
                    end
                end else if (bus.start) begin
                    m_inflight = 1'b1;
                    m_busy     = 1'b1;
                    m_left     = SIZE + 1;
                    m_pending  = ref_model(bus.func_type, bus.value1, bus.value2);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                chk("busy", 32'(bus.busy), 32'(m_busy));
                chk("done", 32'(bus.done), 32'(m_done));
                chk("result", bus.result, m_result);
                chk("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
            end
        end
    end

    // Issue one op at #1 after an edge; returns at #1 after the edge that raises done.
    // For the first `noise` cycles of the op, start stays high with junk operands.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int noise);
        int k;
        bus.start     = 1'b1;
        bus.func_type = op;
        bus.value1    = a;
        bus.value2    = b;
        k = 0;
        while (k < 100) begin
            @(posedge clk);
            k++;
            #1;
            if (k <= noise) begin
                bus.start     = 1'b1;
                bus.func_type = 3'($urandom_range(0, 7));
                bus.value1    = $urandom();
                bus.value2    = $urandom();
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) break;
        end
        chk({name, "_latency"}, 32'(k), 32'(SIZE + 2));
        chk({name, "_result"}, bus.result, exp);
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t vecs [12];
    int   dones;

    initial begin
        vecs[0]  = '{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        vecs[4]  = '{MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{MD_DIVU,   32'd100,       32'd7,         32'd14};
        vecs[7]  = '{MD_REMU,   32'd100,       32'd7,         32'd2};
        vecs[8]  = '{MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{MD_REMU,   32'd5,         32'd0,         32'd5};
        vecs[10] = '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

        // Pin the model itself to hand-computed values
        for (int i = 0; i < 12; i++)
            chk($sformatf("model_vec%0d", i), ref_model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].e);

        // Reset with start held high: nothing may be accepted
        rst_n         = 1'b0;
        bus.start     = 1'b1;
        bus.func_type = MD_MUL;
        bus.value1    = 32'd9;
        bus.value2    = 32'd9;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", bus.result, 32'd0);

        // First edge with rst_n high accepts; directed ops then issue back-to-back
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 0);

        // start re-asserted while busy must be ignored
        run_op("busy_ignore", MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 20);

        // Reset after CALC step 10, with start asserted on the reset edge
        bus.start     = 1'b1;
        bus.func_type = MD_MUL;
        bus.value1    = 32'd1000;
        bus.value2    = 32'd1000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("midcalc_busy", 32'(bus.busy), 32'd0);
        chk("midcalc_done", 32'(bus.done), 32'd0);
        chk("midcalc_result", bus.result, 32'd0);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        dones     = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("midcalc_no_done", 32'(dones), 32'd0);
        run_op("after_reset_mul", MD_MUL, 32'd3, 32'd4, 32'd12, 0);

        // Random traffic: starts in any cycle, occasional resets; the model checks all
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            rst_n         = ($urandom_range(0, 799) != 0);
            bus.start     = ($urandom_range(0, 2) != 0);
            bus.func_type = 3'($urandom_range(0, 7));
            bus.value1    = rand_operand();
            bus.value2    = rand_operand();
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
